// File: rtl/program_loader.sv
// program_loader: writer side of the instruction memory write port (WE/As/WD).
//   Latency: one mem_we cycle follows the edge that accepts the 4th byte of a word.
//   Backpressure: in_ready drops in IDLE/WRITE/DONE/ERR; a byte moves only on in_valid & in_ready.
//
// Frame format: 2-byte word count N (low byte first), then 4*N data bytes,
// little-endian per word. Words go to addresses 0..N-1. The core is held in
// reset (cpu_rst_n=0) except in DONE, so it never runs from a partial image.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             1-cycle pulse, honoured in IDLE/DONE/ERR only
//   in_valid/in_data  byte stream in; in_ready back-pressures it
//   mem_we/mem_addr/mem_wd  instruction memory write port
//   cpu_rst_n         core reset, high only in DONE
//   busy/done/err     status levels
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   Defined: one trailing byte after the last word must equal the mod-256 sum
//   of all data bytes, otherwise the load ends in ERR.
//   Undefined: the last write goes straight to DONE and no trailing byte is read.

module program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal word count; 17 bits so a 16-bit header can be compared
  // against 2**ADDR_W without overflow.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         n_q, n_d;          // word count from the header
  logic [ADDR_W:0]     idx_q, idx_d;      // current word index
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         word_q, word_d;    // first three bytes of the word in flight
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wd_q, mem_wd_d;
  logic                in_ready_q;
  logic                mem_we_q;
  logic                cpu_rst_n_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;      // running mod-256 sum of data bytes
`endif

  logic                accept;
  logic [15:0]         hdr_n;
  logic                last_word;

  // in_ready is registered, so accept sees exactly what the source sees.
  assign accept    = in_valid & in_ready_q;
  assign hdr_n     = {in_data, n_q[7:0]};
  assign last_word = ((17'(idx_q) + 17'd1) == {1'b0, n_q});

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR_LO;
          n_d        = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end

      S_HDR_LO: begin
        if (accept) begin
          n_d[7:0] = in_data;
          state_d  = S_HDR_HI;
        end
      end

      S_HDR_HI: begin
        if (accept) begin
          n_d = hdr_n;
          // A zero-length or oversized image can never be run; reject early.
          if (hdr_n == 16'd0 || {1'b0, hdr_n} > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d     = {in_data, word_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word; latch the write port now so
            // addr/data are stable for the whole WRITE cycle.
            state_d    = S_WRITE;
            mem_addr_d = idx_q[ADDR_W-1:0];
            mem_wd_d   = {in_data, word_q};
          end
        end
      end

      S_WRITE: begin
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DATA;
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered as decodes of the next state, so each one is a
  // clean flop output that matches the state held during the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      in_ready_q  <= (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                     (state_d == S_DATA)   || (state_d == S_CHK);
      mem_we_q    <= (state_d == S_WRITE);
      cpu_rst_n_q <= (state_d == S_DONE);
      busy_q      <= (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                     (state_d == S_DATA)   || (state_d == S_WRITE)  ||
                     (state_d == S_CHK);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of frames plus hand-written sequences for
// mid-load reset and the trailing checksum byte. Expected writes are queued as
// bytes are driven and popped whenever the DUT pulses mem_we.

module tb_program_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hdr;
    int          nw;
    bit          gaps;
    int          seed;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
  } wr_t;

  wr_t               exp_q[$];
  logic [31:0]       img [0:1023];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                we_cnt  = 0;
  logic [ADDR_W-1:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every clock advance goes through here so no write pulse is missed.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      we_cnt++;
      last_addr = mem_addr;
      chk("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {22'd0, mem_addr}, {22'd0, e.addr});
        chk("write_data", mem_wd, e.wd);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc_now;
    bit taken;
    int guard;
    in_valid = 1'b1;
    in_data  = b;
    taken    = 1'b0;
    guard    = 0;
    while (!taken && guard < 64) begin
      acc_now = in_ready;
      tick();
      if (acc_now) taken = 1'b1;
      guard++;
    end
    in_valid = 1'b0;
    if (!taken) chk("byte_accept_timeout", 32'd0, 32'd1);
    if (gaps) tick();
  endtask

  task automatic push_exp(input int idx, input logic [31:0] w);
    wr_t e;
    e.addr = ADDR_W'(idx);
    e.wd   = w;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_cleared_by_start", {31'd0, done}, 32'd0);
    chk("err_cleared_by_start", {31'd0, err}, 32'd0);
    chk("cpu_rst_n_low_loading", {31'd0, cpu_rst_n}, 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] hdr, input int nw, input bit gaps,
                           input bit corrupt, input bit exp_err);
    logic [7:0]  sum;
    logic [31:0] w;
    sum    = 8'd0;
    we_cnt = 0;
    pulse_start();
    send_byte(hdr[7:0], gaps);
    send_byte(hdr[15:8], gaps);
    for (int i = 0; i < nw; i++) begin
      w = img[i];
      push_exp(i, w);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gaps);
        sum = sum + w[8*k +: 8];
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (nw > 0) send_byte(corrupt ? sum + 8'd1 : sum, gaps);
`else
    if (corrupt) sum = 8'd0;
`endif
    tick();
    tick();
    chk("done_level", {31'd0, done}, {31'd0, !exp_err});
    chk("err_level", {31'd0, err}, {31'd0, exp_err});
    chk("cpu_rst_n_end", {31'd0, cpu_rst_n}, {31'd0, !exp_err});
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("in_ready_end", {31'd0, in_ready}, 32'd0);
    chk("write_count", we_cnt, nw);
    chk("pending_writes", exp_q.size(), 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'd2,    2,    1'b0, 0, 1'b0};  // basic two-word image
    vecs[1] = '{16'd2,    2,    1'b1, 0, 1'b0};  // same, valid toggling
    vecs[2] = '{16'd0,    0,    1'b0, 0, 1'b1};  // empty image
    vecs[3] = '{16'h0401, 0,    1'b0, 0, 1'b1};  // one past capacity
    vecs[4] = '{16'd3,    3,    1'b1, 7, 1'b0};
    vecs[5] = '{16'hFFFF, 0,    1'b0, 0, 1'b1};
    vecs[6] = '{16'h0400, 1024, 1'b0, 9, 1'b0};  // full depth

    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].seed == 0) begin
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
      end else begin
        for (int i = 0; i < vecs[v].nw; i++) begin
          img[i] = (vecs[v].seed * 32'h9E37_79B9) ^ (i * 32'h0100_0193) ^ i;
        end
      end
      run_frame(vecs[v].hdr, vecs[v].nw, vecs[v].gaps, 1'b0, vecs[v].exp_err);
      if (vecs[v].nw == 1024) chk("last_addr_full_depth", {22'd0, last_addr}, 32'h3FF);
    end

    // Reset after five data bytes: only word 0 may have been written.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    we_cnt = 0;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    push_exp(0, img[0]);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("midrst_mem_wd", mem_wd, 32'd0);
    chk("midrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done_err", {30'd0, done, err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_write_count", we_cnt, 32'd1);
    chk("midrst_pending", exp_q.size(), 32'd0);
    run_frame(16'd2, 2, 1'b0, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img[0] = 32'hDDCC_BBAA;
    run_frame(16'd1, 1, 1'b0, 1'b0, 1'b0);   // trailing 0x0E
    run_frame(16'd1, 1, 1'b0, 1'b1, 1'b1);   // trailing 0x0F
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
